// File: rtl/alu_pkg.sv
// Shared opcodes, status codes and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1110;
  localparam logic [3:0] OP_SUB = 4'b1101;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_DIV = 4'b0111;

  localparam logic [2:0] ST_POS  = 3'd0;
  localparam logic [2:0] ST_NEG  = 3'd1;
  localparam logic [2:0] ST_DIV0 = 3'd2;
  localparam logic [2:0] ST_ILL  = 3'd3;
  localparam logic [2:0] ST_FRAC = 3'd4;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/alu_div_seq.sv
// Restoring divider, one quotient bit per step, MSB first. quot_nxt is the
// quotient including the bit produced this cycle; it is complete when last=1.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int W  = 4,
  parameter int QW = 11
) (
  input  logic          clk_ALU,
  input  logic          rst_ALU,
  input  logic          load,
  input  logic          step,
  input  logic [QW-1:0] dividend,
  input  logic [W-1:0]  divisor,
  output logic [QW-1:0] quot_nxt,
  output logic          last
);
  localparam int CW = $clog2(QW + 1);

  logic [QW-1:0] dvd_q, quo_q;
  logic [W-1:0]  rem_q, dsr_q, rem_nxt, diff;
  logic [W:0]    shifted;
  logic [CW-1:0] cnt_q;
  logic          ge;

  // remainder is always < divisor, so the trial difference fits in W bits
  always_comb begin
    shifted  = {rem_q, dvd_q[QW-1]};
    ge       = (shifted >= {1'b0, dsr_q});
    diff     = shifted[W-1:0] - dsr_q;
    rem_nxt  = ge ? diff : shifted[W-1:0];
    quot_nxt = {quo_q[QW-2:0], ge};
    last     = (cnt_q == CW'(QW - 1));
  end

  always_ff @(posedge clk_ALU) begin
    if (rst_ALU) begin
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      dvd_q <= dividend;
      dsr_q <= divisor;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      dvd_q <= dvd_q << 1;
      rem_q <= rem_nxt;
      quo_q <= quot_nxt;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/mul, multi-cycle scaled divide.
// Divider is compiled in only when macro ALU_DIV_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int SCALE = 100,
  parameter int RES_W = 11
) (
  input  logic             clk_ALU,
  input  logic             rst_ALU,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic [2:0]       status
);
  localparam int QW = W + 7;

  generate
    if (RES_W < max2(2 * W, QW)) begin : g_res_w_chk
      $fatal(1, "alu_seq: RES_W too small for W");
    end
    if (SCALE < 1 || SCALE > 127) begin : g_scale_chk
      $fatal(1, "alu_seq: SCALE out of range 1..127");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [RES_W-1:0] result_nxt;
  logic [2:0]       status_nxt;

`ifdef ALU_DIV_EN
  logic          div_load, div_last;
  logic [QW-1:0] div_q;

  alu_div_seq #(.W(W), .QW(QW)) u_div (
    .clk_ALU  (clk_ALU),
    .rst_ALU  (rst_ALU),
    .load     (div_load),
    .step     (state == DIV),
    .dividend (QW'(a) * QW'(SCALE)),
    .divisor  (b),
    .quot_nxt (div_q),
    .last     (div_last)
  );
`endif

  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    status_nxt = status;
`ifdef ALU_DIV_EN
    div_load   = 1'b0;
`endif
    case (state)
      IDLE: if (start) begin
        state_nxt = DONE;
        case (op)
          OP_ADD: begin
            result_nxt = RES_W'(a) + RES_W'(b);
            status_nxt = ST_POS;
          end
          OP_SUB: begin
            if (a >= b) begin
              result_nxt = RES_W'(a - b);
              status_nxt = ST_POS;
            end else begin
              result_nxt = RES_W'(b - a);
              status_nxt = ST_NEG;
            end
          end
          OP_MUL: begin
            result_nxt = RES_W'(a) * RES_W'(b);
            status_nxt = ST_POS;
          end
`ifdef ALU_DIV_EN
          OP_DIV: begin
            // divide-by-zero keeps the previous result
            if (b == '0) status_nxt = ST_DIV0;
            else begin
              div_load  = 1'b1;
              state_nxt = DIV;
            end
          end
`endif
          default: begin
            result_nxt = '0;
            status_nxt = ST_ILL;
          end
        endcase
      end
      DIV: begin
`ifdef ALU_DIV_EN
        if (div_last) begin
          result_nxt = RES_W'(div_q);
          status_nxt = ST_FRAC;
          state_nxt  = DONE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ALU) begin
    if (rst_ALU) begin
      state  <= IDLE;
      result <= '0;
      status <= ST_POS;
    end else begin
      state  <= state_nxt;
      result <= result_nxt;
      status <= status_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (W=4, SCALE=100, RES_W=11);
// expectations follow the ALU_DIV_EN setting of the build.
module tb_alu_seq;
  localparam int W = 4, SCALE = 100, RES_W = 11;

  logic             clk_ALU = 1'b0;
  logic             rst_ALU, start;
  logic [3:0]       op;
  logic [W-1:0]     a, b;
  logic             busy, done;
  logic [RES_W-1:0] result;
  logic [2:0]       status;

  int checks = 0, failures = 0;

  alu_seq #(.W(W), .SCALE(SCALE), .RES_W(RES_W)) dut (
    .clk_ALU (clk_ALU),
    .rst_ALU (rst_ALU),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .status  (status)
  );

  always #5 clk_ALU = ~clk_ALU;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    int           res;
    int           st;
    bit           keep;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int  cyc;
    int  last_res;
    int  exp_res;
    bit  seen_done;

    vecs.push_back('{4'b1110, 4'd7,  4'd5,  1, 12,  0, 1'b0});
    vecs.push_back('{4'b1101, 4'd3,  4'd9,  1, 6,   1, 1'b0});
    vecs.push_back('{4'b1101, 4'd9,  4'd3,  1, 6,   0, 1'b0});
    vecs.push_back('{4'b1101, 4'd5,  4'd5,  1, 0,   0, 1'b0});
    vecs.push_back('{4'b1011, 4'd15, 4'd15, 1, 225, 0, 1'b0});
    vecs.push_back('{4'b1110, 4'd15, 4'd15, 1, 30,  0, 1'b0});
    vecs.push_back('{4'b0000, 4'd9,  4'd4,  1, 0,   3, 1'b0});
    vecs.push_back('{4'b1011, 4'd6,  4'd7,  1, 42,  0, 1'b0});
`ifdef ALU_DIV_EN
    vecs.push_back('{4'b0111, 4'd7,  4'd3,  12, 233,  4, 1'b0});
    vecs.push_back('{4'b0111, 4'd5,  4'd0,  1,  0,    2, 1'b1});
    vecs.push_back('{4'b0111, 4'd15, 4'd1,  12, 1500, 4, 1'b0});
    vecs.push_back('{4'b0111, 4'd1,  4'd15, 12, 6,    4, 1'b0});
    vecs.push_back('{4'b0111, 4'd15, 4'd0,  1,  0,    2, 1'b1});
`else
    vecs.push_back('{4'b0111, 4'd7,  4'd3,  1, 0, 3, 1'b0});
    vecs.push_back('{4'b1110, 4'd1,  4'd2,  1, 3, 0, 1'b0});
    vecs.push_back('{4'b0111, 4'd5,  4'd0,  1, 0, 3, 1'b0});
`endif
    vecs.push_back('{4'b1111, 4'd1,  4'd1,  1, 0,  3, 1'b0});

    rst_ALU = 1'b1; start = 1'b0; op = 4'b0000; a = '0; b = '0;
    repeat (3) @(negedge clk_ALU);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_status", status, 0);
    rst_ALU = 1'b0;
    last_res = 0;

`ifdef ALU_DIV_EN
    // reset in the 5th divide cycle, colliding with a fresh start
    @(negedge clk_ALU);
    start = 1'b1; op = 4'b0111; a = 4'd7; b = 4'd3;
    @(negedge clk_ALU);
    start = 1'b0;
    repeat (4) @(negedge clk_ALU);
    rst_ALU = 1'b1; start = 1'b1; op = 4'b1110; a = 4'd2; b = 4'd2;
    @(negedge clk_ALU);
    chk("rst_div_busy", busy, 0);
    chk("rst_div_done", done, 0);
    chk("rst_div_result", result, 0);
    chk("rst_div_status", status, 0);
    rst_ALU = 1'b0; start = 1'b0;
    seen_done = 1'b0;
    repeat (15) begin
      @(negedge clk_ALU);
      if (done) seen_done = 1'b1;
    end
    chk("rst_div_no_done", int'(seen_done), 0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk_ALU);
      start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk_ALU);
      // keep start high with a different add: must be ignored while busy
      op = 4'b1110; a = 4'd1; b = 4'd1;
      cyc = 1;
      while (!done && cyc < 40) begin
        @(negedge clk_ALU);
        cyc++;
      end
      exp_res = vecs[i].keep ? last_res : vecs[i].res;
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), busy, 1);
      chk($sformatf("v%0d_result", i), result, exp_res);
      chk($sformatf("v%0d_status", i), status, vecs[i].st);
      @(negedge clk_ALU);
      chk($sformatf("v%0d_idle_after_done", i), {busy, done}, 0);
      chk($sformatf("v%0d_result_hold", i), result, exp_res);
      start = 1'b0;
      last_res = exp_res;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
